// File: rtl/control_mac.sv
// control_mac: sequential multiply-accumulate FIR engine.
//
// Each accepted start shifts a new sample into a TAPS-deep history, then
// walks the taps one per clock. Each tap's 2N-bit product with the coefficient
// read from an external combinational table is added to a wrapping 2N-bit
// accumulator. A final cycle rescales the sum by F fractional bits and clamps
// it to N bits.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request one computation (sampled in IDLE only)
//   x_in       signed sample captured on the accepted start
//   clr_hist   zero the sample history (sampled in IDLE only)
//   coef_addr  tap index driven to the coefficient table (0 when not in MAC)
//   coef_data  signed coefficient for coef_addr, same cycle
//   busy       high in MAC and SAT
//   done       one-cycle pulse when y_out/sat update
//   y_out      signed, clamped filter result, held until the next done
//   sat        y_out was clamped
module control_mac #(
  parameter int N    = 25,
  parameter int TAPS = 5,
  parameter int F    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N-1:0]            x_in,
  input  logic                    clr_hist,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [N-1:0]            coef_data,
  output logic                    busy,
  output logic                    done,
  output logic [N-1:0]            y_out,
  output logic                    sat
);

  localparam int AW   = $clog2(TAPS);
  localparam int ACCW = 2 * N;

  // Clamp limits expressed at accumulator width.
  localparam logic signed [ACCW-1:0] YMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

  state_t                  state_q;
  logic [AW-1:0]           k_q;
  logic signed [ACCW-1:0]  acc_q;
  logic signed [N-1:0]     hist_q [TAPS];
  logic [N-1:0]            y_q;
  logic                    sat_q;
  logic                    done_q;

  logic signed [N-1:0]     tap_d;
  logic signed [N-1:0]     coef_d;
  logic signed [ACCW-1:0]  prod_d;
  logic signed [ACCW-1:0]  acc_d;
  logic [N:0]              res_d;

  // Arithmetic shift floors toward minus infinity; result packs {sat, y}.
  function automatic logic [N:0] saturate(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] r;
    r = a >>> F;
    if (r > YMAX)      saturate = {1'b1, YMAX[N-1:0]};
    else if (r < YMIN) saturate = {1'b1, YMIN[N-1:0]};
    else               saturate = {1'b0, r[N-1:0]};
  endfunction

  assign tap_d  = hist_q[k_q];
  assign coef_d = $signed(coef_data);
  assign prod_d = tap_d * coef_d;
  // Wraps modulo 2^(2N) by width; overflow is deliberately silent.
  assign acc_d  = acc_q + prod_d;
  assign res_d  = saturate(acc_q);

  assign coef_addr = (state_q == MAC) ? k_q : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign y_out     = y_q;
  assign sat       = sat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // clr_hist together with start keeps only the new sample.
            for (int i = 1; i < TAPS; i++)
              hist_q[i] <= clr_hist ? '0 : hist_q[i-1];
            hist_q[0] <= $signed(x_in);
            acc_q     <= '0;
            k_q       <= '0;
            state_q   <= MAC;
          end else if (clr_hist) begin
            for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (k_q == AW'(TAPS - 1)) begin
            state_q <= SAT;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        SAT: begin
          sat_q   <= res_d[N];
          y_q     <= res_d[N-1:0];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
